// File: rtl/usb_pkg.sv
// Shared constants and types for the USB host transaction scheduler.
// Optional USB_SCHED_ERRCNT_EN adds error and NAK counters to usb_txn_sched.
package usb_pkg;

  localparam int PKT_W   = 99;
  localparam int PID_HI  = 98;
  localparam int PID_LO  = 91;
  localparam int ADDR_HI = 90;
  localparam int ADDR_LO = 84;
  localparam int ENDP_HI = 83;
  localparam int ENDP_LO = 80;
  localparam int DATA_HI = 90;
  localparam int DATA_LO = 27;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOK,
    S_DATA,
    S_RX_HS,
    S_RX_DATA,
    S_HS_ACK,
    S_RETRY,
    S_RESP
  } sched_state_t;

  typedef enum logic [1:0] {
    SP_FIRE,
    SP_LOW,
    SP_HIGH
  } send_phase_t;

  typedef enum logic [2:0] {
    PK_NONE,
    PK_TOK_OUT,
    PK_TOK_IN,
    PK_DATA,
    PK_ACK
  } pkt_kind_t;

endpackage

// File: rtl/usb_pkt_builder.sv
// Combinational formatter for outbound token, data and handshake packets.
// Unused kinds produce an all-zero packet.
module usb_pkt_builder
  import usb_pkg::*;
(
  input  pkt_kind_t         kind,
  input  logic [6:0]        addr,
  input  logic [3:0]        endp,
  input  logic              toggle,
  input  logic [63:0]       data,
  output logic [PKT_W-1:0]  pkt
);

  always_comb begin
    pkt = '0;
    case (kind)
      PK_TOK_OUT, PK_TOK_IN: begin
        pkt[PID_HI:PID_LO] =
          (kind == PK_TOK_IN) ? PID_IN : PID_OUT;
        pkt[ADDR_HI:ADDR_LO] = addr;
        pkt[ENDP_HI:ENDP_LO] = endp;
      end
      PK_DATA: begin
        pkt[PID_HI:PID_LO] =
          toggle ? PID_DATA1 : PID_DATA0;
        pkt[DATA_HI:DATA_LO] = data;
      end
      PK_ACK: pkt[PID_HI:PID_LO] = PID_ACK;
      default: pkt = '0;
    endcase
  end

endmodule

// File: rtl/usb_txn_sched.sv
// Host-side USB transaction scheduler: token/data/handshake sequencing with retry.
// Define USB_SCHED_ERRCNT_EN to add the err_cnt and nak_cnt outputs.
module usb_txn_sched
  import usb_pkg::*;
#(
  parameter int MAX_RETRY   = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_in,
  input  logic [6:0]        req_addr,
  input  logic [3:0]        req_endp,
  input  logic [63:0]       req_data,
  output logic              resp_valid,
  output logic              resp_ok,
  output logic [63:0]       resp_data,
  output logic [PKT_W-1:0]  pkt_in,
  output logic              pkt_in_avail,
  input  logic              encoder_ready,
  input  logic [PKT_W-1:0]  pkt_out,
  input  logic              pkt_out_avail,
  input  logic              data_good,
`ifdef USB_SCHED_ERRCNT_EN
  output logic [15:0]       err_cnt,
  output logic [15:0]       nak_cnt,
`endif
  input  logic              decoder_ready
);

  sched_state_t state, state_nx;
  send_phase_t  sph, sph_nx;
  pkt_kind_t    kind;

  logic [15:0] tcnt, tcnt_nx;
  logic [7:0]  retry, retry_nx;
  logic        toggle, toggle_nx;
  logic        is_in, is_in_nx;
  logic [6:0]  addr, addr_nx;
  logic [3:0]  endp, endp_nx;
  logic [63:0] data, data_nx;
  logic        ok_q, ok_nx;
  logic [63:0] rdata, rdata_nx;

  logic [7:0] pid;
  logic is_ack, is_nak, is_stall, is_data;
  logic send_st, send_done, tmo;
  logic unused_bits;

  assign pid      = pkt_out[PID_HI:PID_LO];
  assign is_ack   = (pid == PID_ACK);
  assign is_nak   = (pid == PID_NAK);
  assign is_stall = (pid == PID_STALL);
  assign is_data  = (pid == PID_DATA0) || (pid == PID_DATA1);
  assign unused_bits = ^pkt_out[DATA_LO-1:0];

  assign send_st = (state == S_TOK) || (state == S_DATA) ||
                   (state == S_HS_ACK);
  // a send finishes once the encoder has gone busy and come back idle
  assign send_done = send_st && (sph == SP_HIGH) && encoder_ready;
  assign tmo = decoder_ready && (tcnt == 16'(TIMEOUT_CYC - 1));

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign resp_ok    = (state == S_RESP) && ok_q;
  assign resp_data  = rdata;

  usb_pkt_builder u_bld (
    .kind   (kind),
    .addr   (addr),
    .endp   (endp),
    .toggle (toggle),
    .data   (data),
    .pkt    (pkt_in)
  );

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state  <= S_IDLE;
      sph    <= SP_FIRE;
      tcnt   <= '0;
      retry  <= '0;
      toggle <= 1'b0;
      is_in  <= 1'b0;
      addr   <= '0;
      endp   <= '0;
      data   <= '0;
      ok_q   <= 1'b0;
      rdata  <= '0;
    end else begin
      state  <= state_nx;
      sph    <= sph_nx;
      tcnt   <= tcnt_nx;
      retry  <= retry_nx;
      toggle <= toggle_nx;
      is_in  <= is_in_nx;
      addr   <= addr_nx;
      endp   <= endp_nx;
      data   <= data_nx;
      ok_q   <= ok_nx;
      rdata  <= rdata_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    sph_nx       = sph;
    tcnt_nx      = tcnt;
    retry_nx     = retry;
    toggle_nx    = toggle;
    is_in_nx     = is_in;
    addr_nx      = addr;
    endp_nx      = endp;
    data_nx      = data;
    ok_nx        = ok_q;
    rdata_nx     = rdata;
    kind         = PK_NONE;
    pkt_in_avail = 1'b0;

    if (send_st) begin
      case (sph)
        SP_FIRE: if (encoder_ready) sph_nx = SP_LOW;
        SP_LOW:  if (!encoder_ready) sph_nx = SP_HIGH;
        SP_HIGH: if (encoder_ready) sph_nx = SP_FIRE;
        default: sph_nx = SP_FIRE;
      endcase
      pkt_in_avail = (sph == SP_FIRE) && encoder_ready;
    end

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          is_in_nx = req_is_in;
          addr_nx  = req_addr;
          endp_nx  = req_endp;
          data_nx  = req_data;
          retry_nx = '0;
          state_nx = S_TOK;
        end
      end
      S_TOK: begin
        kind = is_in ? PK_TOK_IN : PK_TOK_OUT;
        if (send_done) begin
          tcnt_nx  = '0;
          state_nx = is_in ? S_RX_DATA : S_DATA;
        end
      end
      S_DATA: begin
        kind = PK_DATA;
        if (send_done) begin
          tcnt_nx  = '0;
          state_nx = S_RX_HS;
        end
      end
      S_RX_HS: begin
        if (pkt_out_avail) begin
          if (!data_good) state_nx = S_RETRY;
          else begin
            unique case (1'b1)
              is_ack: begin
                toggle_nx = ~toggle;
                ok_nx     = 1'b1;
                state_nx  = S_RESP;
              end
              is_stall: begin
                ok_nx    = 1'b0;
                state_nx = S_RESP;
              end
              default: state_nx = S_RETRY;
            endcase
          end
        end else if (tmo) state_nx = S_RETRY;
        else if (decoder_ready) tcnt_nx = tcnt + 16'd1;
      end
      S_RX_DATA: begin
        if (pkt_out_avail) begin
          if (!data_good) state_nx = S_RETRY;
          else begin
            unique case (1'b1)
              is_data: begin
                rdata_nx = pkt_out[DATA_HI:DATA_LO];
                state_nx = S_HS_ACK;
              end
              is_stall: begin
                ok_nx    = 1'b0;
                state_nx = S_RESP;
              end
              default: state_nx = S_RETRY;
            endcase
          end
        end else if (tmo) state_nx = S_RETRY;
        else if (decoder_ready) tcnt_nx = tcnt + 16'd1;
      end
      S_HS_ACK: begin
        kind = PK_ACK;
        if (send_done) begin
          toggle_nx = ~toggle;
          ok_nx     = 1'b1;
          state_nx  = S_RESP;
        end
      end
      S_RETRY: begin
        retry_nx = retry + 8'd1;
        if (retry == 8'(MAX_RETRY - 1)) begin
          ok_nx    = 1'b0;
          state_nx = S_RESP;
        end else state_nx = S_TOK;
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef USB_SCHED_ERRCNT_EN
  logic nak_ev, err_ev;

  assign nak_ev = ((state == S_RX_HS) || (state == S_RX_DATA)) &&
                  pkt_out_avail && data_good && is_nak;
  assign err_ev = (state_nx == S_RESP) && (state != S_RESP) &&
                  !ok_nx;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      err_cnt <= '0;
      nak_cnt <= '0;
    end else begin
      if (err_ev && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
      if (nak_ev && (nak_cnt != 16'hFFFF))
        nak_cnt <= nak_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_txn_sched.sv
// Bench for usb_txn_sched: encoder/device models, scripted and random replies.
// Expected packet streams and responses come from a per-attempt transfer model.
module tb_usb_txn_sched;

  localparam int MAXR = 8;
  localparam int TMO  = 255;

  localparam int R_ACK   = 0;
  localparam int R_NAK   = 1;
  localparam int R_STALL = 2;
  localparam int R_NONE  = 3;
  localparam int R_BAD   = 4;
  localparam int R_JUNK  = 5;
  localparam int R_DATA  = 6;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_in;
  logic [6:0]  req_addr;
  logic [3:0]  req_endp;
  logic [63:0] req_data;
  logic        resp_valid;
  logic        resp_ok;
  logic [63:0] resp_data;
  logic [98:0] pkt_in;
  logic        pkt_in_avail;
  logic        encoder_ready;
  logic [98:0] pkt_out;
  logic        pkt_out_avail;
  logic        data_good;
  logic        decoder_ready;
`ifdef USB_SCHED_ERRCNT_EN
  logic [15:0] err_cnt;
  logic [15:0] nak_cnt;
`endif

  usb_txn_sched #(.MAX_RETRY(MAXR), .TIMEOUT_CYC(TMO)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_in     (req_is_in),
    .req_addr      (req_addr),
    .req_endp      (req_endp),
    .req_data      (req_data),
    .resp_valid    (resp_valid),
    .resp_ok       (resp_ok),
    .resp_data     (resp_data),
    .pkt_in        (pkt_in),
    .pkt_in_avail  (pkt_in_avail),
    .encoder_ready (encoder_ready),
    .pkt_out       (pkt_out),
    .pkt_out_avail (pkt_out_avail),
    .data_good     (data_good),
`ifdef USB_SCHED_ERRCNT_EN
    .err_cnt       (err_cnt),
    .nak_cnt       (nak_cnt),
`endif
    .decoder_ready (decoder_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [98:0] sent_q[$];
  int          sent_cyc[$];
  int          dev_q[$];
  int          script_q[$];
  logic [98:0] exp_q[$];
  logic [63:0] dev_payload;
  bit          exp_ok;
  logic [63:0] exp_data;
  bit          mdl_toggle;
  int          exp_nak;
  int          exp_err;

  function automatic logic [98:0] mk_tok(bit in, logic [6:0] a,
                                         logic [3:0] e);
    logic [98:0] p;
    p = '0;
    p[98:91] = in ? 8'h69 : 8'hE1;
    p[90:84] = a;
    p[83:80] = e;
    return p;
  endfunction

  function automatic logic [98:0] mk_data(bit tog, logic [63:0] d);
    logic [98:0] p;
    p = '0;
    p[98:91] = tog ? 8'h4B : 8'hC3;
    p[90:27] = d;
    return p;
  endfunction

  function automatic logic [98:0] mk_hs(logic [7:0] pid);
    logic [98:0] p;
    p = '0;
    p[98:91] = pid;
    return p;
  endfunction

  // device: answers each OUT data packet or IN token with the next scripted reply
  task automatic device_reply();
    int r;
    r = (dev_q.size() == 0) ? R_NONE : dev_q.pop_front();
    if (r == R_NONE) return;
    repeat ($urandom_range(1, 6)) begin
      @(posedge clk);
      #1 decoder_ready = ($urandom_range(0, 3) != 0);
    end
    case (r)
      R_ACK:   pkt_out = mk_hs(8'hD2);
      R_NAK:   pkt_out = mk_hs(8'h5A);
      R_STALL: pkt_out = mk_hs(8'h1E);
      R_JUNK:  pkt_out = mk_hs(8'hA5);
      R_BAD:   pkt_out = req_is_in ?
                 mk_data(1'($urandom), dev_payload) : mk_hs(8'hD2);
      default: pkt_out = mk_data(1'($urandom), dev_payload);
    endcase
    data_good     = (r != R_BAD);
    pkt_out_avail = 1'b1;
    decoder_ready = 1'b1;
    @(posedge clk);
    #1;
    pkt_out_avail = 1'b0;
    data_good     = 1'b0;
    pkt_out       = '0;
  endtask

  // encoder: logs each pulse, goes busy for a few cycles, then triggers the device
  initial begin
    logic [98:0] p;
    forever begin
      @(negedge clk);
      if (pkt_in_avail && !rst_b) begin
        n_cmp++;
        if (!encoder_ready) begin
          n_bad++;
          $display("FAIL send_rule: pkt_in_avail=1 with encoder_ready=%0b, required 1",
                   encoder_ready);
        end
        p = pkt_in;
        sent_q.push_back(p);
        sent_cyc.push_back(cyc);
        @(posedge clk);
        #1 encoder_ready = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 encoder_ready = 1'b1;
        if (p[98:91] == 8'h69 || p[98:91] == 8'hC3 ||
            p[98:91] == 8'h4B)
          device_reply();
      end
    end
  end

  // transfer model: one scripted reply per attempt, up to MAXR attempts
  task automatic model_txn(bit in, logic [6:0] a, logic [3:0] e,
                           logic [63:0] d);
    int r;
    bit done;
    exp_q.delete();
    exp_ok   = 1'b0;
    exp_data = '0;
    done     = 1'b0;
    for (int k = 0; k < MAXR && !done; k++) begin
      r = (k < script_q.size()) ? script_q[k] : R_NONE;
      exp_q.push_back(mk_tok(in, a, e));
      if (!in) begin
        exp_q.push_back(mk_data(mdl_toggle, d));
        if (r == R_ACK) begin
          exp_ok = 1'b1;
          mdl_toggle = ~mdl_toggle;
          done = 1'b1;
        end else if (r == R_STALL) done = 1'b1;
      end else begin
        if (r == R_DATA) begin
          exp_q.push_back(mk_hs(8'hD2));
          exp_ok = 1'b1;
          exp_data = dev_payload;
          mdl_toggle = ~mdl_toggle;
          done = 1'b1;
        end else if (r == R_STALL) done = 1'b1;
      end
      if (r == R_NAK) exp_nak++;
    end
    if (!exp_ok) exp_err++;
  endtask

  task automatic issue_req(bit in, logic [6:0] a, logic [3:0] e,
                           logic [63:0] d, input string name);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_is_in = in;
    req_addr  = a;
    req_endp  = e;
    req_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s accept: req_ready stayed 0, required 1", name);
    end
  endtask

  task automatic run_txn(input string name, bit in, logic [6:0] a,
                         logic [3:0] e, logic [63:0] d);
    bit seen;
    int bad_idx;
    model_txn(in, a, e, d);
    dev_q = script_q;
    sent_q.delete();
    sent_cyc.delete();
    issue_req(in, a, e, d, name);
    seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s resp_timeout: no resp_valid, required one", name);
    end else begin
      n_cmp++;
      if (resp_ok !== exp_ok) begin
        n_bad++;
        $display("FAIL %s resp_ok: got %0b required %0b",
                 name, resp_ok, exp_ok);
      end
      if (exp_ok && in) begin
        n_cmp++;
        if (resp_data !== exp_data) begin
          n_bad++;
          $display("FAIL %s resp_data: got %h required %h",
                   name, resp_data, exp_data);
        end
      end
      n_cmp++;
      bad_idx = -1;
      if (sent_q.size() != exp_q.size()) bad_idx = 999;
      else
        for (int i = 0; i < exp_q.size(); i++)
          if (sent_q[i] !== exp_q[i]) begin
            bad_idx = i;
            break;
          end
      if (bad_idx == 999) begin
        n_bad++;
        $display("FAIL %s pkt_count: got %0d required %0d",
                 name, sent_q.size(), exp_q.size());
      end else if (bad_idx >= 0) begin
        n_bad++;
        $display("FAIL %s pkt[%0d]: got %h required %h", name,
                 bad_idx, sent_q[bad_idx], exp_q[bad_idx]);
      end
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL %s resp_pulse: resp_valid got %0b required 0",
                 name, resp_valid);
      end
`ifdef USB_SCHED_ERRCNT_EN
      n_cmp++;
      if (nak_cnt !== 16'(exp_nak) || err_cnt !== 16'(exp_err)) begin
        n_bad++;
        $display("FAIL %s counters: nak %0d err %0d required %0d %0d",
                 name, nak_cnt, err_cnt, exp_nak, exp_err);
      end
`endif
    end
    dev_q.delete();
  endtask

  task automatic check_idle(input string name);
    n_cmp++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 ||
        resp_ok !== 1'b0 || pkt_in_avail !== 1'b0 ||
        pkt_in !== '0) begin
      n_bad++;
      $display("FAIL %s: rdy %b rv %b ok %b avail %b pkt %h required 1 0 0 0 0",
               name, req_ready, resp_valid, resp_ok, pkt_in_avail, pkt_in);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    n_cmp++;
    if (resp_data !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_resp_data: got %h required 0", resp_data);
    end
    @(posedge clk);
    #1 rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("post_reset_idle");
  endtask

  task automatic test_out_ack();
    script_q = '{R_ACK};
    run_txn("out_ack1", 1'b0, 7'h05, 4'h1, 64'hDEADBEEF_01234567);
    n_cmp++;
    if (sent_q.size() < 2 || sent_q[0][98:91] !== 8'hE1 ||
        sent_q[1][98:91] !== 8'hC3) begin
      n_bad++;
      $display("FAIL out_ack1_pids: got %0d pkts, required E1 then C3",
               sent_q.size());
    end
    script_q = '{R_ACK};
    run_txn("out_ack2", 1'b0, 7'h05, 4'h1, 64'h0);
    n_cmp++;
    if (sent_q.size() < 2 || sent_q[1][98:91] !== 8'h4B) begin
      n_bad++;
      $display("FAIL out_ack2_pid: got %0d pkts, required DATA1 4B",
               sent_q.size());
    end
  endtask

  task automatic test_in_data();
    dev_payload = 64'h1122334455667788;
    script_q = '{R_DATA};
    run_txn("in_data", 1'b1, 7'h12, 4'h3, 64'h0);
    n_cmp++;
    if (resp_data !== 64'h1122334455667788 || sent_q.size() != 2 ||
        sent_q[1][98:91] !== 8'hD2) begin
      n_bad++;
      $display("FAIL in_data_direct: data %h pkts %0d, required 1122334455667788 and ACK",
               resp_data, sent_q.size());
    end
  endtask

  task automatic test_out_nak();
    script_q = '{R_NAK, R_NAK, R_ACK};
    run_txn("out_nak", 1'b0, 7'h22, 4'h2, 64'hA5A5_5A5A_0F0F_F0F0);
    n_cmp++;
    if (sent_q.size() != 6) begin
      n_bad++;
      $display("FAIL out_nak_pairs: got %0d pkts required 6",
               sent_q.size());
    end
  endtask

  task automatic test_in_timeout();
    int gap;
    script_q.delete();
    run_txn("in_timeout", 1'b1, 7'h33, 4'h4, 64'h0);
    n_cmp++;
    if (sent_q.size() != MAXR || resp_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL in_timeout_tokens: got %0d required %0d",
               sent_q.size(), MAXR);
    end
    for (int i = 1; i < sent_cyc.size(); i++) begin
      gap = sent_cyc[i] - sent_cyc[i-1];
      n_cmp++;
      if (gap < TMO + 3 || gap > TMO + 7) begin
        n_bad++;
        $display("FAIL in_timeout_gap[%0d]: got %0d required %0d..%0d",
                 i, gap, TMO + 3, TMO + 7);
      end
    end
  endtask

  task automatic test_out_stall();
    script_q = '{R_STALL};
    run_txn("out_stall", 1'b0, 7'h44, 4'h5, 64'h1234);
    n_cmp++;
    if (sent_q.size() != 2 || sent_q[1][98:91] !== 8'hC3) begin
      n_bad++;
      $display("FAIL out_stall_single: got %0d pkts required 2 with C3",
               sent_q.size());
    end
    script_q = '{R_ACK};
    run_txn("after_stall", 1'b0, 7'h44, 4'h5, 64'h5678);
    n_cmp++;
    if (sent_q.size() < 2 || sent_q[1][98:91] !== 8'hC3) begin
      n_bad++;
      $display("FAIL stall_toggle: data pid not C3 (pkts %0d)",
               sent_q.size());
    end
  endtask

  task automatic test_random();
    int r;
    bit in;
    for (int t = 0; t < 24; t++) begin
      in = 1'($urandom);
      dev_payload = {$urandom, $urandom};
      script_q.delete();
      for (int k = 0; k < MAXR; k++) begin
        r = $urandom_range(0, 19);
        if (r == 0) script_q.push_back(R_NONE);
        else if (r <= 2) script_q.push_back(R_STALL);
        else if (r <= 7) script_q.push_back(R_NAK);
        else if (r <= 9) script_q.push_back(R_BAD);
        else if (r == 10) script_q.push_back(R_JUNK);
        else script_q.push_back(in ? R_DATA : R_ACK);
      end
      run_txn($sformatf("rand%0d", t), in, 7'($urandom),
              4'($urandom), {$urandom, $urandom});
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    bit bad_seen;
    script_q.delete();
    dev_q.delete();
    sent_q.delete();
    issue_req(1'b1, 7'h55, 4'h6, 64'h0, "reset_mid");
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sent_q.size() != 0) begin
        got = 1'b1;
        break;
      end
    end
    repeat (10) @(posedge clk);
    #1 rst_b = 1'b1;
    #1;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL reset_mid_token: no IN token sent, required one");
    end
    check_idle("reset_mid_outputs");
    mdl_toggle = 1'b0;
    exp_nak = 0;
    exp_err = 0;
    @(posedge clk);
    #1 rst_b = 1'b0;
    bad_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_valid || pkt_in_avail) bad_seen = 1'b1;
    end
    n_cmp++;
    if (bad_seen) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: activity after abort, required none");
    end
    script_q = '{R_ACK};
    run_txn("post_abort", 1'b0, 7'h55, 4'h6, 64'hCAFE);
  endtask

  initial begin
    rst_b         = 1'b1;
    req_valid     = 1'b0;
    req_is_in     = 1'b0;
    req_addr      = '0;
    req_endp      = '0;
    req_data      = '0;
    encoder_ready = 1'b1;
    pkt_out       = '0;
    pkt_out_avail = 1'b0;
    data_good     = 1'b0;
    decoder_ready = 1'b1;
    dev_payload   = '0;
    mdl_toggle    = 1'b0;
    exp_nak       = 0;
    exp_err       = 0;
    test_reset();
    test_out_ack();
    test_in_data();
    test_out_nak();
    test_in_timeout();
    test_out_stall();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
